// File: rtl/packet_link_arbiter.sv
// Round-robin owner of the shared byte link: one whole packet per grant,
// forced idle gap between packets, bounded start latency and packet length.
module packet_link_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned GAP_CYCLES    = 1,
  parameter int unsigned MAX_PKT_LEN   = 255,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqValid,
  output logic [7:0]           packet,
  output logic                 packetValid,
  output logic                 busy,
  output logic [15:0]          abortCount
);

  localparam int unsigned PW   = $clog2(NUM_REQ);
  localparam int unsigned TMAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, GAP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, gidx_q, pick_idx, rr_next;
  logic               pick_found;
  logic [TW-1:0]      timer_q;
  logic [7:0]         byte_cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         packet_q;
  logic               pv_q;
  logic [15:0]        abort_q;
  logic [7:0]         lane_data [NUM_REQ];
  logic               lane_valid;
  logic               do_grant, do_fwd, do_drop, do_abort;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned cand;
    logic [PW-1:0] cand_p;
    cand       = 0;
    cand_p     = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand   = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_p = PW'(cand);
      if (!pick_found && req[cand_p]) begin
        pick_found = 1'b1;
        pick_idx   = cand_p;
      end
    end
    rr_next = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lane_data[i] = reqData[8*i +: 8];
    end
    lane_valid = reqValid[gidx_q];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_fwd   = 1'b0;
    do_drop  = 1'b0;
    do_abort = 1'b0;
    case (state_q)
      IDLE: if (pick_found) begin
        state_d  = WAIT;
        do_grant = 1'b1;
      end
      WAIT: if (lane_valid) begin
        state_d = XFER;
        do_fwd  = 1'b1;
      end else if (timer_q == TW'(START_TIMEOUT)) begin
        state_d  = GAP;
        do_drop  = 1'b1;
        do_abort = 1'b1;
      end
      XFER: if (!lane_valid) begin
        state_d = GAP;
        do_drop = 1'b1;
      end else if (byte_cnt_q == 8'(MAX_PKT_LEN)) begin
        state_d  = GAP;
        do_drop  = 1'b1;
        do_abort = 1'b1;
      end else begin
        do_fwd = 1'b1;
      end
      GAP: if (timer_q == TW'(GAP_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    grant       = grant_q;
    packet      = packet_q;
    packetValid = pv_q;
    abortCount  = abort_q;
  end

  // Timer restarts on every state change; it serves as start timeout in WAIT and gap length in GAP.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      timer_q    <= '0;
      byte_cnt_q <= '0;
      grant_q    <= '0;
      packet_q   <= '0;
      pv_q       <= 1'b0;
      abort_q    <= '0;
    end else begin
      timer_q <= (state_d != state_q) ? '0 : timer_q + 1'b1;
      if (do_grant) begin
        grant_q  <= NUM_REQ'(1) << pick_idx;
        gidx_q   <= pick_idx;
        rr_ptr_q <= rr_next;
      end else if (do_drop) begin
        grant_q <= '0;
      end
      if (do_fwd) begin
        packet_q   <= lane_data[gidx_q];
        pv_q       <= 1'b1;
        byte_cnt_q <= (state_q == XFER) ? byte_cnt_q + 1'b1 : 8'd1;
      end else begin
        packet_q <= '0;
        pv_q     <= 1'b0;
      end
      if (do_abort && abort_q != '1) abort_q <= abort_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_link_arbiter.sv
// Scoreboard bench for packet_link_arbiter: directed packets, expected bytes,
// lengths and grant order queued by stimulus and checked by a link monitor.
module tb_packet_link_arbiter;
  localparam int NUM_REQ       = 4;
  localparam int GAP_CYCLES    = 1;
  localparam int MAX_PKT_LEN   = 255;
  localparam int START_TIMEOUT = 15;

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ-1:0]   grant;
  logic [8*NUM_REQ-1:0] reqData = '0;
  logic [NUM_REQ-1:0]   reqValid = '0;
  logic [7:0]           packet;
  logic                 packetValid;
  logic                 busy;
  logic [15:0]          abortCount;

  int checks = 0;
  int errors = 0;
  logic [7:0]         exp_bytes[$];
  int                 exp_len[$];
  logic [NUM_REQ-1:0] exp_grant[$];
  logic               mon_en = 1'b0;

  packet_link_arbiter #(
    .NUM_REQ(NUM_REQ),
    .GAP_CYCLES(GAP_CYCLES),
    .MAX_PKT_LEN(MAX_PKT_LEN),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .req(req),
    .grant(grant),
    .reqData(reqData),
    .reqValid(reqValid),
    .packet(packet),
    .packetValid(packetValid),
    .busy(busy),
    .abortCount(abortCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int idx, input int k);
    return 8'(idx * 16 + k + 1);
  endfunction

  function automatic logic gbit(input int i);
    logic [NUM_REQ-1:0] t;
    t = grant >> i;
    return t[0];
  endfunction

  // Link monitor: byte order, packet lengths, idle gap, grant order.
  int run = 0;
  int idle = 100;
  logic [NUM_REQ-1:0] prev_grant = '0;
  always @(negedge CLK) begin
    if (!RESET_N || !mon_en) begin
      run = 0;
      idle = 100;
      prev_grant = '0;
    end else begin
      if (prev_grant == '0 && grant != '0) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(grant), 32'd0);
        else chk("grant_order", 32'(grant), 32'(exp_grant.pop_front()));
      end
      prev_grant = grant;
      if (packetValid) begin
        if (run == 0) chk("link_gap_ok", 32'(idle >= GAP_CYCLES + 1), 32'd1);
        run++;
        idle = 0;
        if (exp_bytes.size() == 0) chk("byte_unexpected", 32'(packet), 32'h100);
        else chk("link_byte", 32'(packet), 32'(exp_bytes.pop_front()));
      end else begin
        chk("packet_zero_when_idle", 32'(packet), 32'd0);
        if (run > 0) begin
          if (exp_len.size() == 0) chk("len_unexpected", run, 32'd0);
          else chk("packet_len", run, exp_len.pop_front());
          run = 0;
        end
        idle++;
      end
    end
  end

  task automatic reset_dut();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b0;
    req = '0;
    reqValid = '0;
    reqData = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_packetValid", 32'(packetValid), 32'd0);
    chk("rst_packet", 32'(packet), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_abortCount", 32'(abortCount), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    mon_en = 1'b1;
  endtask

  // Acts as whichever requester currently owns the link; sends n bytes.
  task automatic serve(input int n, output int idx);
    int sent;
    idx = -1;
    sent = 0;
    for (int w = 0; w < 100 && idx < 0; w++) begin
      @(negedge CLK);
      for (int i = 0; i < NUM_REQ; i++) if (gbit(i)) idx = i;
    end
    chk("grant_arrives", 32'(idx >= 0), 32'd1);
    if (idx < 0) return;
    exp_len.push_back(n < MAX_PKT_LEN ? n : MAX_PKT_LEN);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == 0) chk("link_idle_at_grant", 32'(packetValid), 32'd0);
      if (k == 1) chk("first_byte_latency", 32'(packetValid), 32'd1);
      if (!gbit(idx)) break;
      if (k < MAX_PKT_LEN) exp_bytes.push_back(pat(idx, k));
      reqData = (reqData & ~(32'hFF << (8 * idx))) | (32'(pat(idx, k)) << (8 * idx));
      reqValid = reqValid | (NUM_REQ'(1) << idx);
      sent++;
    end
    if (sent == n) begin
      @(negedge CLK);
      chk("grant_hold_last", 32'(gbit(idx)), 32'd1);
    end
    reqValid = reqValid & ~(NUM_REQ'(1) << idx);
    reqData = '0;
    @(negedge CLK);
    chk("grant_release", 32'(gbit(idx)), 32'd0);
  endtask

  // Requester idx never sends; returns cycles from grant rise to grant fall.
  task automatic timeout_grant(input int idx, output int cyc);
    int got;
    got = 0;
    cyc = -1;
    for (int w = 0; w < 40 && got == 0; w++) begin
      @(negedge CLK);
      if (gbit(idx)) got = 1;
    end
    chk("timeout_grant_seen", got, 32'd1);
    if (got == 0) return;
    chk("busy_in_wait", 32'(busy), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (!gbit(idx)) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int idx;
    int cyc;
    logic [NUM_REQ-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    reset_dut();

    // 1: single 10-byte packet from requester 0
    req = 4'b0001;
    exp_grant.push_back(4'b0001);
    serve(10, idx);
    req = '0;
    chk("t1_idx", idx, 32'd0);
    chk("t1_abort", 32'(abortCount), 32'd0);

    // 2: all requesting, 3-byte packets, round-robin from 0
    reset_dut();
    req = 4'b1111;
    for (int p = 0; p < 5; p++) exp_grant.push_back(order[p]);
    for (int p = 0; p < 5; p++) begin
      serve(3, idx);
      chk("t2_idx", 32'(NUM_REQ'(1) << idx), 32'(order[p]));
    end
    req = '0;

    // 3: requester 2 never sends -> timeout, then requester 3 served
    req = 4'b0100;
    exp_grant.push_back(4'b0100);
    timeout_grant(2, cyc);
    req = '0;
    chk("t3_timeout_cycles", cyc, 32'd16);
    chk("t3_abort", 32'(abortCount), 32'd1);
    req = 4'b1000;
    exp_grant.push_back(4'b1000);
    serve(2, idx);
    req = '0;
    chk("t3_next_idx", idx, 32'd3);

    // 4: 300-byte stream truncated to MAX_PKT_LEN
    req = 4'b0010;
    exp_grant.push_back(4'b0010);
    serve(300, idx);
    req = '0;
    chk("t4_idx", idx, 32'd1);
    chk("t4_abort", 32'(abortCount), 32'd2);

    // 5: asynchronous reset mid-transfer
    repeat (3) @(negedge CLK);
    chk("t5_pre_bytes_empty", exp_bytes.size(), 32'd0);
    chk("t5_pre_len_empty", exp_len.size(), 32'd0);
    mon_en = 1'b0;
    req = 4'b1000;
    idx = -1;
    for (int w = 0; w < 20 && idx < 0; w++) begin
      @(negedge CLK);
      if (grant[3]) idx = 3;
    end
    chk("t5_grant3", idx, 32'd3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge CLK);
      reqData = 32'(pat(3, k)) << 24;
      reqValid = 4'b1000;
    end
    @(negedge CLK);
    chk("t5_xfer_active", 32'(packetValid), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'd0);
    chk("t5_async_pv", 32'(packetValid), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_abort", 32'(abortCount), 32'd0);
    reqValid = '0;
    reqData = '0;
    req = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    mon_en = 1'b1;
    req = 4'b1001;
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b1000);
    serve(2, idx);
    req[0] = 1'b0;
    chk("t5_first_after_reset", idx, 32'd0);
    serve(2, idx);
    req = '0;
    chk("t5_second_after_reset", idx, 32'd3);

    // 6: abortCount saturation
    @(negedge CLK);
    force dut.abort_q = 16'hFFFE;
    #1;
    release dut.abort_q;
    req = 4'b0100;
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b0100);
    timeout_grant(2, cyc);
    chk("t6_timeout_cycles", cyc, 32'd16);
    chk("t6_abort_reach_max", 32'(abortCount), 32'hFFFF);
    timeout_grant(2, cyc);
    req = '0;
    chk("t6_abort_saturate", 32'(abortCount), 32'hFFFF);

    repeat (6) @(negedge CLK);
    chk("end_bytes_empty", exp_bytes.size(), 32'd0);
    chk("end_len_empty", exp_len.size(), 32'd0);
    chk("end_grant_empty", exp_grant.size(), 32'd0);
    chk("end_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
